// File: rtl/hamming74_encoder_stream.sv
// Hamming(7,4) stream encoder: encodes accepted nibbles and queues the
// codewords, with optional single-bit error injection, in a small FIFO.
module hamming74_encoder_stream #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_data,
    input  logic [2:0]               in_inj,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [6:0]               out_code,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         sent_cnt,
    output logic [CNT_W-1:0]         inj_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] LVL_FULL = (PTR_W+1)'(DEPTH);

    function automatic logic [6:0] encode(input logic [3:0] d);
        logic p1, p2, p3;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p3 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p3, d[0], p2, p1};
    endfunction

    // Position k (1..7) lives in bit k-1; zero means no flip.
    function automatic logic [6:0] inject(input logic [6:0] code, input logic [2:0] pos);
        logic [6:0] mask;
        mask = (pos == 3'd0) ? 7'd0 : (7'd1 << (pos - 3'd1));
        return code ^ mask;
    endfunction

    logic [6:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [6:0]       code_p0;
    logic             vld_p0;
    logic             pop;

    // Input stage: encode and inject, decide push/pop from registered state
    assign in_ready  = (fifo_level != LVL_FULL);
    assign out_valid = (fifo_level != '0);
    assign vld_p0    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign code_p0   = inject(encode(in_data), in_inj);
    assign out_code  = mem[rd_ptr];

    // Storage stage: codeword payload is never reset
    always_ff @(posedge wb_clk_i) begin
        if (vld_p0) begin
            mem[wr_ptr] <= code_p0;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            sent_cnt   <= '0;
            inj_cnt    <= '0;
        end else begin
            if (vld_p0) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (vld_p0 && (in_inj != 3'd0)) begin
                inj_cnt <= inj_cnt + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                sent_cnt <= sent_cnt + CNT_W'(1);
            end
            case ({vld_p0, pop})
                2'b10:   fifo_level <= fifo_level + (PTR_W+1)'(1);
                2'b01:   fifo_level <= fifo_level - (PTR_W+1)'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming74_encoder_stream.sv
// Bench for hamming74_encoder_stream: directed scenarios plus randomized
// traffic, checked every cycle against a queue-based reference model.
module tb_hamming74_encoder_stream;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = 4'd0;
    logic [2:0] in_inj = 3'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [6:0] out_code;
    logic [2:0] fifo_level;
    logic [7:0] sent_cnt;
    logic [7:0] inj_cnt;

    int n_cmp = 0;
    int n_err = 0;

    hamming74_encoder_stream #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_inj     (in_inj),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_code   (out_code),
        .fifo_level (fifo_level),
        .sent_cnt   (sent_cnt),
        .inj_cnt    (inj_cnt)
    );

    always #5 clk = ~clk;

    // Reference codeword built by Hamming position: data at 3,5,6,7, parity
    // at power-of-two positions covering every position sharing that bit.
    function automatic logic [6:0] model_code(input logic [3:0] d, input logic [2:0] inj);
        logic [7:1] pos;
        pos = '0;
        pos[3] = d[0];
        pos[5] = d[1];
        pos[6] = d[2];
        pos[7] = d[3];
        for (int i = 0; i < 3; i++) begin
            int  p;
            logic x;
            p = 1 << i;
            x = 1'b0;
            for (int k = 1; k <= 7; k++) begin
                if (((k & p) != 0) && (k != p)) x = x ^ pos[k];
            end
            pos[p] = x;
        end
        if (inj != 3'd0) pos[inj] = ~pos[inj];
        return pos;
    endfunction

    logic [6:0] q[$];
    logic [7:0] m_sent = 8'd0;
    logic [7:0] m_inj  = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on the same edges the DUT sees
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_sent <= 8'd0;
            m_inj  <= 8'd0;
        end else begin
            automatic bit do_push = in_valid && (q.size() < DEPTH);
            automatic bit do_pop  = (q.size() > 0) && out_ready;
            if (do_pop) begin
                void'(q.pop_front());
                m_sent <= m_sent + 8'd1;
            end
            if (do_push) begin
                q.push_back(model_code(in_data, in_inj));
                if (in_inj != 3'd0) m_inj <= m_inj + 8'd1;
            end
        end
    end

    // Per-cycle comparison away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            check("out_valid", out_valid, (q.size() != 0));
            check("in_ready", in_ready, (q.size() != DEPTH));
            check("fifo_level", fifo_level, q.size());
            check("sent_cnt", sent_cnt, m_sent);
            check("inj_cnt", inj_cnt, m_inj);
            if (q.size() != 0) check("out_code", out_code, q[0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        check("model_1011", model_code(4'b1011, 3'd0), 7'b1010101);
        check("model_0001", model_code(4'b0001, 3'd0), 7'b0000111);
        check("model_F_inj3", model_code(4'hF, 3'd3), 7'b1111011);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_level", fifo_level, 3'd0);
        check("rst_sent", sent_cnt, 8'd0);
        check("rst_inj", inj_cnt, 8'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single word, one cycle latency
        in_valid = 1'b1; in_data = 4'b1011; in_inj = 3'd0;
        tick();
        in_valid = 1'b0;
        check("t1_valid", out_valid, 1'b1);
        check("t1_code", out_code, 7'b1010101);
        out_ready = 1'b1;
        tick();
        check("t1_sent", sent_cnt, 8'd1);
        check("t1_level", fifo_level, 3'd0);

        // Back-to-back with out_ready high
        in_valid = 1'b1; in_data = 4'h0;
        tick();
        check("t2_code0", out_code, 7'b0000000);
        in_data = 4'hF;
        tick();
        check("t2_code1", out_code, 7'b1111111);
        in_data = 4'b0001;
        tick();
        check("t2_code2", out_code, 7'b0000111);
        in_valid = 1'b0;
        tick();
        check("t2_empty", out_valid, 1'b0);

        // Error injection
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 4'hF; in_inj = 3'd3;
        tick();
        check("t3_code_a", out_code, 7'b1111011);
        check("t3_inj_a", inj_cnt, 8'd1);
        out_ready = 1'b1; in_data = 4'h0; in_inj = 3'd7;
        tick();
        in_valid = 1'b0; in_inj = 3'd0;
        check("t3_code_b", out_code, 7'b1000000);
        check("t3_inj_b", inj_cnt, 8'd2);
        tick();
        out_ready = 1'b0;

        // Fill to full, then pop while full
        in_valid = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            in_data = 4'(i);
            tick();
        end
        check("t4_ready_low", in_ready, 1'b0);
        check("t4_level_full", fifo_level, 3'd4);
        in_data = 4'd5;
        tick();
        check("t4_no_push", fifo_level, 3'd4);
        out_ready = 1'b1;
        tick();
        check("t4_pop_only", fifo_level, 3'd3);
        check("t4_head", out_code, model_code(4'd2, 3'd0));
        out_ready = 1'b0;
        tick();
        check("t4_push_after", fifo_level, 3'd4);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (DEPTH) tick();
        check("t4_drained", fifo_level, 3'd0);

        // Steady stream at level 2
        out_ready = 1'b0; in_valid = 1'b1;
        repeat (2) begin
            in_data = 4'($urandom_range(0, 15));
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = 4'($urandom_range(0, 15));
            tick();
            check("t5_level2", fifo_level, 3'd2);
        end
        in_valid = 1'b0;
        repeat (3) tick();

        // Asynchronous reset with level 3
        out_ready = 1'b0; in_valid = 1'b1;
        repeat (3) begin
            in_data = 4'($urandom_range(0, 15));
            in_inj  = 3'($urandom_range(0, 7));
            tick();
        end
        in_valid = 1'b0; in_inj = 3'd0;
        check("t6_pre_level", fifo_level, 3'd3);
        #2 rst = 1'b1;
        #1;
        check("t6_valid", out_valid, 1'b0);
        check("t6_ready", in_ready, 1'b1);
        check("t6_level", fifo_level, 3'd0);
        check("t6_sent", sent_cnt, 8'd0);
        check("t6_inj", inj_cnt, 8'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        in_valid = 1'b1; in_data = 4'hA;
        tick();
        in_valid = 1'b0;
        check("t6_new_code", out_code, 7'b1010010);
        check("t6_new_level", fifo_level, 3'd1);
        out_ready = 1'b1;
        tick();
        check("t6_new_sent", sent_cnt, 8'd1);
        check("t6_empty", out_valid, 1'b0);

        // Randomized traffic, long enough to wrap both counters
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = 4'($urandom_range(0, 15));
            in_inj    = 3'($urandom_range(0, 7));
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (DEPTH + 1) tick();
        check("final_empty", fifo_level, 3'd0);

        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
